// File: rtl/alu_cmd_sequencer_if.sv
// rtl/alu_cmd_sequencer_if.sv - host-side command and response port bundle
interface alu_cmd_sequencer_if #(
    parameter int DATA_W = 8
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [2:0]            cmd_op;
    logic [DATA_W-1:0]     cmd_a;
    logic [DATA_W-1:0]     cmd_b;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [2*DATA_W-1:0]   rsp_result;
    logic [2:0]            rsp_op;
    logic                  rsp_err;

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_result, rsp_op, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
        output cmd_ready, rsp_valid, rsp_result, rsp_op, rsp_err
    );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - buffered command engine driving the TinyALU start/done handshake
module alu_cmd_sequencer #(
    parameter int DATA_W     = 8,
    parameter int DEPTH      = 4,
    parameter int TIMEOUT    = 16,
    parameter int RST_CYCLES = 2
) (
    input  logic                clk,
    input  logic                reset,
    alu_cmd_sequencer_if.slave  host,
    output logic                alu_start,
    output logic [2:0]          alu_op,
    output logic [DATA_W-1:0]   alu_a,
    output logic [DATA_W-1:0]   alu_b,
    output logic                alu_rst,
    input  logic                alu_done,
    input  logic [2*DATA_W-1:0] alu_result,
    output logic                busy
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam int RC_W  = $clog2(RST_CYCLES + 1);
    localparam int ENT_W = 3 + 2 * DATA_W;

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_RST = 3'b111;

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT_DONE, S_RST_PULSE, S_RESP} state_t;

    state_t              state_q, state_d;
    logic [ENT_W-1:0]    fifo_mem_q [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [2:0]          alu_op_q, alu_op_d;
    logic [DATA_W-1:0]   alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [TMO_W-1:0]    tmo_cnt_q, tmo_cnt_d;
    logic [RC_W-1:0]     rst_cnt_q, rst_cnt_d;
    logic [2*DATA_W-1:0] rsp_result_q, rsp_result_d;
    logic [2:0]          rsp_op_q, rsp_op_d;
    logic                rsp_err_q, rsp_err_d;

    logic                fifo_full, fifo_empty, push, pop;
    logic [ENT_W-1:0]    head;
    logic [2:0]          head_op;
    logic [DATA_W-1:0]   head_a, head_b;

    assign fifo_full  = (count_q == CNT_W'(DEPTH));
    assign fifo_empty = (count_q == '0);
    assign push       = host.cmd_valid && !fifo_full;
    assign head       = fifo_mem_q[rd_ptr_q];
    assign head_op    = head[ENT_W-1 -: 3];
    assign head_a     = head[2*DATA_W-1 -: DATA_W];
    assign head_b     = head[DATA_W-1:0];

    always_comb begin
        state_d      = state_q;
        alu_op_d     = alu_op_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        tmo_cnt_d    = tmo_cnt_q;
        rst_cnt_d    = rst_cnt_q;
        rsp_result_d = rsp_result_q;
        rsp_op_d     = rsp_op_q;
        rsp_err_d    = rsp_err_q;
        pop          = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop = 1'b1;
                    case (head_op)
                        OP_RST: begin
                            state_d   = S_RST_PULSE;
                            rst_cnt_d = '0;
                        end
                        3'b101, 3'b110: begin
                            // Illegal ops never touch the ALU pins.
                            state_d      = S_RESP;
                            rsp_op_d     = head_op;
                            rsp_err_d    = 1'b1;
                            rsp_result_d = '0;
                        end
                        default: begin
                            state_d  = S_ISSUE;
                            alu_op_d = head_op;
                            alu_a_d  = head_a;
                            alu_b_d  = head_b;
                        end
                    endcase
                end
            end
            S_ISSUE: begin
                tmo_cnt_d = TMO_W'(1);
                rsp_op_d  = alu_op_q;
                state_d   = (alu_op_q == OP_NOP) ? S_IDLE : S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (alu_done) begin
                    rsp_result_d = alu_result;
                    rsp_err_d    = 1'b0;
                    state_d      = S_RESP;
                end else if (tmo_cnt_q >= TMO_W'(TIMEOUT - 1)) begin
                    rsp_result_d = '0;
                    rsp_err_d    = 1'b1;
                    state_d      = S_RESP;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            S_RST_PULSE: begin
                if (rst_cnt_q == RC_W'(RST_CYCLES - 1)) state_d = S_IDLE;
                else                                    rst_cnt_d = rst_cnt_q + 1'b1;
            end
            S_RESP: begin
                if (host.rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            alu_op_q     <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            tmo_cnt_q    <= '0;
            rst_cnt_q    <= '0;
            rsp_result_q <= '0;
            rsp_op_q     <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            alu_op_q     <= alu_op_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            tmo_cnt_q    <= tmo_cnt_d;
            rst_cnt_q    <= rst_cnt_d;
            rsp_result_q <= rsp_result_d;
            rsp_op_q     <= rsp_op_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    // Storage needs no reset: entries are only read once count_q says they were written.
    always_ff @(posedge clk) begin
        if (push) fifo_mem_q[wr_ptr_q] <= {host.cmd_op, host.cmd_a, host.cmd_b};
    end

    assign host.cmd_ready  = !fifo_full;
    assign host.rsp_valid  = (state_q == S_RESP);
    assign host.rsp_result = rsp_result_q;
    assign host.rsp_op     = rsp_op_q;
    assign host.rsp_err    = rsp_err_q;
    assign alu_start       = (state_q == S_ISSUE) || (state_q == S_WAIT_DONE);
    assign alu_rst         = (state_q == S_RST_PULSE);
    assign alu_op          = alu_op_q;
    assign alu_a           = alu_a_q;
    assign alu_b           = alu_b_q;
    assign busy            = (state_q != S_IDLE) || !fifo_empty;
endmodule
